// File: rtl/qbert_cube_tracker_if.sv
// Avalon-MM bus between the NIOS master and the Qbert cube tracker.
// Read latency is one clock and there is no waitrequest.
interface qbert_cube_tracker_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/qbert_cube_tracker.sv
// Tracks Qbert's cube on the pyramid, resolves jump landings and owns the
// top-face colour vector; the NIOS reads state and resets the pyramid over Avalon.
module qbert_cube_tracker #(
  parameter int N_cube = 27,
  parameter int N_rank = 7
) (
  input  logic              i_clk_33,
  input  logic              i_reset_n,
  input  logic              i_nios_start_qbert,
  input  logic [2:0]        i_qbert_jump,
  input  logic              i_done_move,
  output logic              o_bad_jump,
  output logic              o_qbert_busy,
  output logic [N_cube:0]   o_nios_top_color,
  output logic [4:0]        o_cube_index,
  output logic              o_level_done,
  qbert_cube_tracker_if.slave avs
);

  // state     | meaning
  // S_IDLE    | standing on a cube, waiting for a legal jump start
  // S_WAIT_LOW| drop any stale done_move left over from the previous jump
  // S_WAIT_HIGH| animation running, wait for done_move
  // S_RESOLVE | one cycle: land on target or fall off
  // S_FELL    | off the pyramid, only a pyramid reset leaves
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LOW, S_WAIT_HIGH, S_RESOLVE, S_FELL
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_code;
  logic [3:0]         r_rank, r_pos;
  logic [4:0]         r_cube_index;
  logic [N_cube:0]    r_color, w_color_nxt, w_land_mask;
  logic [15:0]        r_count;
  logic               r_level_done;
  logic [31:0]        r_readdata;

  logic               w_ctl_wr, w_ctl_reset, w_ctl_apex, w_col_wr, w_code_legal;
  logic signed [3:0]  w_dr, w_dp, w_tr, w_tp;
  logic               w_tgt_ok, w_land;
  logic [4:0]         w_tgt_idx;
  logic               w_unused_wdata;

  function automatic logic [4:0] cube_idx(input logic [3:0] rk, input logic [3:0] ps);
    return 5'((({2'b0, rk} * ({2'b0, rk} - 6'd1)) >> 1) + {2'b0, ps} - 6'd1);
  endfunction

  assign w_ctl_wr     = avs.avs_write && (avs.avs_address == 2'd3);
  assign w_ctl_reset  = w_ctl_wr && avs.avs_writedata[0];
  assign w_ctl_apex   = w_ctl_wr && avs.avs_writedata[1];
  assign w_col_wr     = avs.avs_write && (avs.avs_address == 2'd0);
  assign w_code_legal = (i_qbert_jump != 3'd0) && (i_qbert_jump <= 3'd4);
  assign w_unused_wdata = ^avs.avs_writedata[31:N_cube+1];

  always_comb begin
    w_dr = 4'sd0;
    w_dp = 4'sd0;
    case (r_code)
      3'd1: w_dr = 4'sd1;
      3'd2: begin w_dr = 4'sd1;  w_dp = 4'sd1;  end
      3'd3: begin w_dr = -4'sd1; w_dp = -4'sd1; end
      3'd4: w_dr = -4'sd1;
      default: ;
    endcase
  end

  // Rank 7 + 1 wraps to -8 in 4-bit signed, which the pos<=rank test rejects.
  assign w_tr      = $signed(r_rank) + w_dr;
  assign w_tp      = $signed(r_pos) + w_dp;
  assign w_tgt_ok  = (w_tp >= 4'sd1) && (w_tp <= w_tr) && (w_tr <= $signed(4'(N_rank)));
  assign w_tgt_idx = cube_idx($unsigned(w_tr), $unsigned(w_tp));
  assign w_land    = (r_state == S_RESOLVE) && w_tgt_ok && !w_ctl_reset;

  always_comb begin
    w_land_mask = '0;
    if (w_land) w_land_mask[w_tgt_idx] = 1'b1;
    w_color_nxt = r_color;
    if (w_col_wr) w_color_nxt = avs.avs_writedata[N_cube:0];
    w_color_nxt = w_color_nxt | w_land_mask;
    if (w_ctl_reset) w_color_nxt = '0;
    if (w_ctl_apex) w_color_nxt[0] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (i_nios_start_qbert && w_code_legal) w_state_nxt = S_WAIT_LOW;
      S_WAIT_LOW:  if (!i_done_move) w_state_nxt = S_WAIT_HIGH;
      S_WAIT_HIGH: if (i_done_move) w_state_nxt = S_RESOLVE;
      S_RESOLVE:   w_state_nxt = w_tgt_ok ? S_IDLE : S_FELL;
      S_FELL:      w_state_nxt = S_FELL;
      default:     w_state_nxt = S_IDLE;
    endcase
    if (w_ctl_reset) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk_33 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_code       <= 3'd0;
      r_rank       <= 4'd1;
      r_pos        <= 4'd1;
      r_cube_index <= 5'd0;
      r_color      <= '0;
      r_count      <= 16'd0;
      r_level_done <= 1'b0;
      r_readdata   <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_color      <= w_color_nxt;
      r_level_done <= &r_color;
      if (r_state == S_IDLE && i_nios_start_qbert && w_code_legal) r_code <= i_qbert_jump;
      if (w_ctl_reset) begin
        r_rank       <= 4'd1;
        r_pos        <= 4'd1;
        r_cube_index <= 5'd0;
        r_count      <= 16'd0;
      end else if (w_land) begin
        r_rank       <= $unsigned(w_tr);
        r_pos        <= $unsigned(w_tp);
        r_cube_index <= w_tgt_idx;
        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      end
      if (avs.avs_read) begin
        case (avs.avs_address)
          2'd0:    r_readdata <= 32'(r_color);
          2'd1:    r_readdata <= {16'd0, r_level_done, (r_state == S_FELL), o_qbert_busy,
                                  r_cube_index, r_rank, r_pos};
          2'd2:    r_readdata <= {16'd0, r_count};
          default: r_readdata <= 32'd0;
        endcase
      end
    end
  end

  assign o_qbert_busy     = (r_state == S_WAIT_LOW) || (r_state == S_WAIT_HIGH) ||
                            (r_state == S_RESOLVE);
  assign o_bad_jump       = (r_state == S_RESOLVE) && !w_tgt_ok && !w_ctl_reset;
  assign o_nios_top_color = r_color;
  assign o_cube_index     = r_cube_index;
  assign o_level_done     = r_level_done;
  assign avs.avs_readdata = r_readdata;

endmodule

// File: tb/tb_qbert_cube_tracker.sv
// Self-checking bench: directed scenarios plus random jumps against a
// rank/pos/bitmask model of the pyramid game.
module tb_qbert_cube_tracker;
  logic        clk_33 = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  jump = 3'd0;
  logic        done_move = 1'b0;
  logic        bad_jump, busy, level_done;
  logic [27:0] top_color;
  logic [4:0]  cube_index;

  qbert_cube_tracker_if bus ();

  qbert_cube_tracker #(.N_cube(27), .N_rank(7)) dut (
    .i_clk_33(clk_33), .i_reset_n(reset_n),
    .i_nios_start_qbert(start), .i_qbert_jump(jump), .i_done_move(done_move),
    .o_bad_jump(bad_jump), .o_qbert_busy(busy), .o_nios_top_color(top_color),
    .o_cube_index(cube_index), .o_level_done(level_done), .avs(bus.slave)
  );

  always #15 clk_33 = ~clk_33;

  int          n_checks = 0;
  int          n_fail = 0;
  int          m_rank, m_pos, m_count;
  logic [27:0] m_color;
  bit          m_fell;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input int r, input int p);
    return r * (r - 1) / 2 + p - 1;
  endfunction

  task automatic model_reset();
    m_rank = 1; m_pos = 1; m_count = 0; m_color = '0; m_fell = 0;
  endtask

  task automatic tick();
    @(posedge clk_33);
    #1;
  endtask

  task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
    bus.avs_address = a; bus.avs_read = 1'b1;
    tick();
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
    tick();
    bus.avs_write = 1'b0;
    if (a == 2'd0) m_color = d[27:0];
    if (a == 2'd3) begin
      if (d[0]) model_reset();
      if (d[1]) m_color[0] = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    logic [31:0] d, exp_st;
    tick();
    exp_st = '0;
    exp_st[3:0]   = m_pos[3:0];
    exp_st[7:4]   = m_rank[3:0];
    exp_st[12:8]  = 5'(idx_of(m_rank, m_pos));
    exp_st[14]    = m_fell;
    exp_st[15]    = &m_color;
    chk_eq({tag, "_cube"}, 32'(cube_index), 32'(idx_of(m_rank, m_pos)));
    chk_eq({tag, "_color"}, 32'(top_color), 32'(m_color));
    chk_eq({tag, "_level"}, 32'(level_done), 32'(&m_color));
    avs_rd(2'd1, d); chk_eq({tag, "_status"}, d, exp_st);
    avs_rd(2'd0, d); chk_eq({tag, "_rd_color"}, d, 32'(m_color));
    avs_rd(2'd2, d); chk_eq({tag, "_count"}, d, 32'((m_count > 65535) ? 65535 : m_count));
  endtask

  task automatic do_jump(input string tag, input int code, input int gap, input bit hold_high);
    int nr, np, bad_cnt;
    bit active, valid;
    nr = m_rank; np = m_pos; bad_cnt = 0;
    active = (code >= 1) && (code <= 4) && !m_fell;
    case (code)
      1: nr = m_rank + 1;
      2: begin nr = m_rank + 1; np = m_pos + 1; end
      3: begin nr = m_rank - 1; np = m_pos - 1; end
      4: nr = m_rank - 1;
      default: ;
    endcase
    valid = (np >= 1) && (np <= nr) && (nr <= 7);
    if (hold_high) done_move = 1'b1;
    jump = 3'(code); start = 1'b1;
    tick();
    start = 1'b0; jump = 3'($urandom);
    chk_eq({tag, "_busy_start"}, 32'(busy), 32'(active));
    if (hold_high) begin
      repeat (gap + 1) begin tick(); bad_cnt += int'(bad_jump); end
      chk_eq({tag, "_hold_cube"}, 32'(cube_index), 32'(idx_of(m_rank, m_pos)));
      chk_eq({tag, "_hold_busy"}, 32'(busy), 32'(active));
      done_move = 1'b0;
    end
    repeat (gap) begin tick(); bad_cnt += int'(bad_jump); end
    done_move = 1'b1;
    tick(); bad_cnt += int'(bad_jump);
    done_move = 1'b0;
    repeat (4) begin tick(); bad_cnt += int'(bad_jump); end
    if (active) begin
      if (valid) begin
        m_rank = nr; m_pos = np; m_count++;
        m_color[idx_of(nr, np)] = 1'b1;
      end else m_fell = 1;
    end
    chk_eq({tag, "_bad"}, 32'(bad_cnt), 32'(active && !valid));
    chk_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_state(tag);
  endtask

  // Walks the FSM to the RESOLVE cycle and returns there (#1 after the edge).
  task automatic to_resolve(input int code);
    jump = 3'(code); start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    done_move = 1'b1;
    tick();
    done_move = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int code;
    bus.avs_address = 2'd0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    model_reset();
    repeat (3) tick();
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_bad", 32'(bad_jump), 32'd0);
    chk_eq("rst_color", 32'(top_color), 32'd0);
    chk_eq("rst_cube", 32'(cube_index), 32'd0);
    chk_eq("rst_level", 32'(level_done), 32'd0);
    chk_eq("rst_rdata", bus.avs_readdata, 32'd0);
    reset_n = 1'b1;
    check_state("post_rst");

    do_jump("t1_dl", 1, 5, 0);
    chk_eq("t1_cube_abs", 32'(cube_index), 32'd1);
    chk_eq("t1_color_abs", 32'(top_color), 32'h0000002);

    bus_write(2'd3, 32'd1);
    do_jump("t2_ur", 4, 2, 0);
    do_jump("t2_dl_ignored", 1, 2, 0);
    bus_write(2'd3, 32'd1);
    check_state("t2_restore");

    do_jump("t3_first", 2, 1, 0);
    do_jump("t3_hold", 1, 3, 1);

    bus_write(2'd0, 32'h0FFFFFFE);
    bus_write(2'd3, 32'd2);
    chk_eq("t4_level_early", 32'(level_done), 32'd0);
    tick();
    chk_eq("t4_level", 32'(level_done), 32'd1);
    check_state("t4");

    bus_write(2'd3, 32'd1);
    for (int i = 0; i < 5; i++) do_jump("t5_walk", 1, 1, 0);
    do_jump("t5_dr", 2, 1, 0);
    chk_eq("t5_cube_abs", 32'(cube_index), 32'd22);
    do_jump("t5_off", 1, 1, 0);

    // control reset lands on the RESOLVE cycle of a falling jump
    bus_write(2'd3, 32'd1);
    to_resolve(4);
    bus.avs_address = 2'd3; bus.avs_writedata = 32'd1; bus.avs_write = 1'b1;
    #1;
    chk_eq("sim_rst_bad", 32'(bad_jump), 32'd0);
    tick();
    bus.avs_write = 1'b0;
    check_state("sim_rst");

    // colour write in the RESOLVE cycle of a valid landing
    to_resolve(1);
    bus.avs_address = 2'd0; bus.avs_writedata = 32'h0000_0010; bus.avs_write = 1'b1;
    tick();
    bus.avs_write = 1'b0;
    m_rank = 2; m_pos = 1; m_count++; m_color = 28'h0000012;
    check_state("sim_col");

    // read and write in one cycle returns the old value
    bus.avs_address = 2'd0; bus.avs_writedata = 32'h0000_0100;
    bus.avs_write = 1'b1; bus.avs_read = 1'b1;
    tick();
    bus.avs_write = 1'b0; bus.avs_read = 1'b0;
    chk_eq("rw_old", bus.avs_readdata, 32'(m_color));
    m_color = 28'h0000100;
    check_state("rw_new");

    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (m_fell && r < 6) bus_write(2'd3, 32'd1);
      else if (r == 9) bus_write(2'd0, $urandom);
      else if (r == 8) bus_write(2'd3, 32'd2);
      else begin
        code = ($urandom_range(0, 9) < 8) ? $urandom_range(1, 4) : $urandom_range(5, 8) % 8;
        do_jump("rnd", code, $urandom_range(1, 3), $urandom_range(0, 3) == 0);
        continue;
      end
      check_state("rnd_bus");
    end

    // asynchronous reset while the jump waits for done_move
    bus_write(2'd3, 32'd1);
    do_jump("t6_pre", 2, 1, 0);
    jump = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    reset_n = 1'b0;
    #2;
    chk_eq("t6_busy", 32'(busy), 32'd0);
    chk_eq("t6_color", 32'(top_color), 32'd0);
    chk_eq("t6_cube", 32'(cube_index), 32'd0);
    chk_eq("t6_rdata", bus.avs_readdata, 32'd0);
    #5;
    reset_n = 1'b1;
    model_reset();
    tick();
    done_move = 1'b1;
    tick();
    done_move = 1'b0;
    repeat (3) tick();
    chk_eq("t6_bad", 32'(bad_jump), 32'd0);
    chk_eq("t6_busy_after", 32'(busy), 32'd0);
    check_state("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
